// File: rtl/rs_enc_pkg.sv
// Shared defaults, FSM encodings and an elaboration-time GF(2^M) constant
// multiply used to build the fixed multiplier networks.
package rs_enc_pkg;

    localparam int         RS_M    = 5;
    localparam logic [4:0] RS_POLY = 5'b00101;
    localparam int         RS_NPAR = 4;
    localparam int         RS_K    = 27;

    // g(x) = (x+a)(x+a^2)(x+a^3)(x+a^4) over GF(32), a = x; g0 in the low bits
    localparam logic [19:0] RS_GEN_COEF = {5'd30, 5'd6, 5'd9, 5'd17};

    localparam logic [0:0] ST_DATA   = 1'b0;
    localparam logic [0:0] ST_PARITY = 1'b1;

    function automatic logic [7:0] gf_mul_const(input logic [7:0] a,
                                                input logic [7:0] c,
                                                input int         m,
                                                input logic [7:0] poly);
        logic [7:0] acc;
        logic [7:0] sh;
        logic [7:0] mask;
        acc  = '0;
        sh   = a;
        mask = 8'hFF >> (8 - m);
        for (int b = 0; b < 8; b++) begin
            if (b < m) begin
                if (c[b]) begin
                    acc = acc ^ sh;
                end
                sh = sh[m-1] ? (((sh << 1) ^ poly) & mask) : ((sh << 1) & mask);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf_mult_const.sv
// Combinational multiply by a constant in GF(2^M): each input bit selects a
// precomputed column (x^bit * C mod POLY) and the columns are XOR-reduced.
module gf_mult_const
    import rs_enc_pkg::*;
#(
    parameter int         M    = RS_M,
    parameter logic [M-1:0] POLY = M'(RS_POLY),
    parameter logic [M-1:0] C    = '0
) (
    input  logic [M-1:0] a_i,
    output logic [M-1:0] p_o
);

    logic [M-1:0] term [M];
    logic [M-1:0] p_acc;

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_col
            localparam logic [7:0] COL8 = gf_mul_const(8'(1 << gi), 8'(C), M, 8'(POLY));
            assign term[gi] = COL8[M-1:0] & {M{a_i[gi]}};
        end
    endgenerate

    always_comb begin
        p_acc = '0;
        for (int i = 0; i < M; i++) begin
            p_acc = p_acc ^ term[i];
        end
    end

    assign p_o = p_acc;

endmodule

// File: rtl/rs_encoder_serial.sv
// Symbol-serial systematic RS encoder: data passes through a one-deep output
// register, then NPAR parity symbols are shifted out of the generator LFSR.
module rs_encoder_serial
    import rs_enc_pkg::*;
#(
    parameter int                M        = RS_M,
    parameter logic [M-1:0]      POLY     = M'(RS_POLY),
    parameter int                NPAR     = RS_NPAR,
    parameter int                K        = RS_K,
    parameter logic [NPAR*M-1:0] GEN_COEF = (NPAR*M)'(RS_GEN_COEF)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [M-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [M-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    output logic         out_parity,
    input  logic         out_ready,
    output logic         trunc
);

    localparam int             CNT_MAX = (K > NPAR) ? K : NPAR;
    localparam int             CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]  K_LAST  = CW'(K - 1);
    localparam logic [CW-1:0]  P_LAST  = CW'(NPAR - 1);

    logic [0:0]    state_q,      state_d;
    logic [CW-1:0] count_q,      count_d;
    logic [M-1:0]  lfsr_q [NPAR];
    logic [M-1:0]  lfsr_d [NPAR];
    logic [M-1:0]  out_data_q,   out_data_d;
    logic          out_valid_q,  out_valid_d;
    logic          out_last_q,   out_last_d;
    logic          out_parity_q, out_parity_d;
    logic          trunc_q,      trunc_d;

    logic          slot_free;
    logic          accept;
    logic [M-1:0]  fb;
    logic [M-1:0]  fb_prod [NPAR];

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ST_DATA) && slot_free;
    assign accept    = in_valid && in_ready;
    assign fb        = in_data ^ lfsr_q[NPAR-1];

    genvar gi;
    generate
        for (gi = 0; gi < NPAR; gi++) begin : g_mul
            gf_mult_const #(
                .M    (M),
                .POLY (POLY),
                .C    (GEN_COEF[gi*M +: M])
            ) u_mul (
                .a_i (fb),
                .p_o (fb_prod[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        lfsr_d       = lfsr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_parity_d = out_parity_q;
        trunc_d      = 1'b0;

        if (state_q == ST_DATA) begin
            if (accept) begin
                out_data_d   = in_data;
                out_valid_d  = 1'b1;
                out_parity_d = 1'b0;
                out_last_d   = 1'b0;
                lfsr_d[0]    = fb_prod[0];
                for (int i = 1; i < NPAR; i++) begin
                    lfsr_d[i] = lfsr_q[i-1] ^ fb_prod[i];
                end
                // A full-length codeword without in_last is closed anyway and flagged
                if (in_last || count_q == K_LAST) begin
                    state_d = ST_PARITY;
                    count_d = '0;
                    trunc_d = !in_last;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (slot_free) begin
                out_valid_d = 1'b0;
            end
        end else if (slot_free) begin
            out_data_d   = lfsr_q[NPAR-1];
            out_valid_d  = 1'b1;
            out_parity_d = 1'b1;
            out_last_d   = 1'b0;
            lfsr_d[0]    = '0;
            for (int i = 1; i < NPAR; i++) begin
                lfsr_d[i] = lfsr_q[i-1];
            end
            if (count_q == P_LAST) begin
                out_last_d = 1'b1;
                for (int i = 0; i < NPAR; i++) begin
                    lfsr_d[i] = '0;
                end
                count_d = '0;
                state_d = ST_DATA;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_DATA;
            count_q      <= '0;
            lfsr_q       <= '{default: '0};
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_parity_q <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lfsr_q       <= lfsr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_parity_q <= out_parity_d;
            trunc_q      <= trunc_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_parity = out_parity_q;
    assign trunc      = trunc_q;

endmodule

// File: tb/tb_rs_encoder_serial.sv
// Randomised bench for rs_encoder_serial; expected codewords come from
// polynomial long division of d(x)*x^NPAR by g(x).
module tb_rs_encoder_serial;

    localparam int                M    = 5;
    localparam logic [M-1:0]      POLY = 5'b00101;
    localparam int                NPAR = 2;
    localparam int                K    = 8;
    localparam logic [M-1:0]      G [NPAR] = '{5'd2, 5'd3};
    localparam logic [NPAR*M-1:0] GEN_COEF = {5'd3, 5'd2};

    typedef struct {
        logic [M-1:0] data;
        logic         par;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rstn;
    logic [M-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [M-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_parity;
    logic         out_ready;
    logic         trunc;

    int   checks;
    int   failures;
    exp_t exp_q[$];
    bit   trunc_exp;
    bit   stall_en;
    bit   gap_en;
    bit   seen_first;
    int   gaps;
    int   trunc_cnt;
    int   cw_num;

    rs_encoder_serial #(
        .M        (M),
        .POLY     (POLY),
        .NPAR     (NPAR),
        .K        (K),
        .GEN_COEF (GEN_COEF)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_parity (out_parity),
        .out_ready  (out_ready),
        .trunc      (trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Carry-less product followed by reduction with the full field polynomial
    function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] prod;
        logic [2*M-2:0] full;
        prod = '0;
        full = (2*M-1)'({1'b1, POLY});
        for (int i = 0; i < M; i++) begin
            if (b[i]) prod = prod ^ ((2*M-1)'(a) << i);
        end
        for (int k = 2*M-2; k >= M; k--) begin
            if (prod[k]) prod = prod ^ (full << (k - M));
        end
        return prod[M-1:0];
    endfunction

    task automatic push_expect(input logic [M-1:0] d, input logic p, input logic l);
        exp_t e;
        e.data = d;
        e.par  = p;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic push_model(input logic [M-1:0] d[$]);
        logic [M-1:0] rem[$];
        logic [M-1:0] coef;
        int           len;
        len = d.size();
        rem = d;
        repeat (NPAR) rem.push_back('0);
        for (int j = 0; j < len; j++) begin
            coef = rem[j];
            for (int i = 1; i <= NPAR; i++) begin
                rem[j+i] = rem[j+i] ^ gmul(coef, G[NPAR-i]);
            end
        end
        for (int j = 0; j < len; j++) push_expect(d[j], 1'b0, 1'b0);
        for (int i = 0; i < NPAR; i++) push_expect(rem[len+i], 1'b1, i == NPAR-1);
    endtask

    task automatic cycle(output bit acc);
        exp_t e;
        @(negedge clk);
        if (out_valid) begin
            chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("out_data",   32'(out_data),   32'(e.data));
                chk("out_parity", 32'(out_parity), 32'(e.par));
                chk("out_last",   32'(out_last),   32'(e.last));
                if (out_ready) void'(exp_q.pop_front());
            end
            if (gap_en) seen_first = 1'b1;
        end else if (gap_en && seen_first && exp_q.size() != 0) begin
            gaps++;
        end
        chk("trunc", 32'(trunc), 32'(trunc_exp));
        if (trunc) trunc_cnt++;
        trunc_exp = 1'b0;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        out_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic send_syms(input logic [M-1:0] d[$], input bit with_last, input bit idles);
        bit acc;
        int n;
        for (int j = 0; j < d.size(); j++) begin
            if (idles && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom);
                in_data  = M'($urandom);
                cycle(acc);
            end
            in_valid = 1'b1;
            in_data  = d[j];
            in_last  = with_last && (j == d.size() - 1);
            n = 0;
            do begin
                cycle(acc);
                n++;
            end while (!acc && n < 500);
            chk("accept_timeout", 32'(acc), 32'd1);
            if (!acc) return;
            if (j == K-1 && !with_last) trunc_exp = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = M'($urandom);
    endtask

    task automatic send_codeword(input logic [M-1:0] d[$], input bit with_last, input bit idles);
        cw_num++;
        $display("codeword %0d len=%0d in_last=%0d stall=%0d", cw_num, d.size(), with_last, stall_en);
        push_model(d);
        send_syms(d, with_last, idles);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            cycle(acc);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_word(output logic [M-1:0] d[$], output bit with_last);
        int len;
        d.delete();
        len = $urandom_range(1, K);
        for (int i = 0; i < len; i++) d.push_back(M'($urandom));
        with_last = (len < K) ? 1'b1 : 1'($urandom);
    endtask

    initial begin
        logic [M-1:0] dq[$];
        bit           wl;
        bit           acc;
        int           t0;

        checks    = 0;
        failures  = 0;
        trunc_exp = 1'b0;
        stall_en  = 1'b0;
        gap_en    = 1'b0;
        seen_first = 1'b0;
        gaps      = 0;
        trunc_cnt = 0;
        cw_num    = 0;
        rstn      = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_data",   32'(out_data),   32'd0);
        chk("rst_out_last",   32'(out_last),   32'd0);
        chk("rst_out_parity", 32'(out_parity), 32'd0);
        chk("rst_trunc",      32'(trunc),      32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single symbol 1 with in_last -> 1, 3, 2
        $display("codeword directed_1 len=1");
        push_expect(5'd1, 1'b0, 1'b0);
        push_expect(5'd3, 1'b1, 1'b0);
        push_expect(5'd2, 1'b1, 1'b1);
        dq.delete();
        dq.push_back(5'd1);
        send_syms(dq, 1'b1, 1'b0);
        drain();

        // Data 1,0 -> 1, 0, 7, 6
        $display("codeword directed_2 len=2");
        push_expect(5'd1, 1'b0, 1'b0);
        push_expect(5'd0, 1'b0, 1'b0);
        push_expect(5'd7, 1'b1, 1'b0);
        push_expect(5'd6, 1'b1, 1'b1);
        dq.delete();
        dq.push_back(5'd1);
        dq.push_back(5'd0);
        send_syms(dq, 1'b1, 1'b0);
        drain();

        // Full-length all-zero codeword, with and without in_last
        dq.delete();
        repeat (K) dq.push_back('0);
        t0 = trunc_cnt;
        send_codeword(dq, 1'b1, 1'b0);
        drain();
        chk("trunc_none_with_last", 32'(trunc_cnt - t0), 32'd0);
        t0 = trunc_cnt;
        send_codeword(dq, 1'b0, 1'b0);
        drain();
        chk("trunc_once_without_last", 32'(trunc_cnt - t0), 32'd1);

        // Back-to-back codewords with no stalls must produce a gapless stream
        gap_en     = 1'b1;
        seen_first = 1'b0;
        gaps       = 0;
        rand_word(dq, wl);
        send_codeword(dq, wl, 1'b0);
        rand_word(dq, wl);
        send_codeword(dq, wl, 1'b0);
        drain();
        gap_en = 1'b0;
        chk("b2b_gaps", 32'(gaps), 32'd0);

        // Random codewords under random back-pressure and input idles
        stall_en = 1'b1;
        for (int c = 0; c < 100; c++) begin
            rand_word(dq, wl);
            send_codeword(dq, wl, 1'b1);
        end
        drain();
        stall_en  = 1'b0;
        out_ready = 1'b1;

        // Reset asserted while parity is being emitted
        dq.delete();
        dq.push_back(5'd9);
        dq.push_back(5'd22);
        dq.push_back(5'd4);
        send_codeword(dq, 1'b1, 1'b0);
        cycle(acc);
        chk("pre_rst_parity", 32'(out_parity), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid",  32'(out_valid),  32'd0);
        chk("mid_rst_out_data",   32'(out_data),   32'd0);
        chk("mid_rst_out_last",   32'(out_last),   32'd0);
        chk("mid_rst_out_parity", 32'(out_parity), 32'd0);
        exp_q.delete();
        trunc_exp = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle(acc);
        rand_word(dq, wl);
        send_codeword(dq, wl, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d expected=%0d", $time, 2000000);
        $fatal(1, "timeout");
    end

endmodule
